// File: rtl/demux4_pkg.sv
// Shared types and frame geometry for the 4-channel TDM receiver.
// DEMUX4_PARITY_EN adds a fifth (even parity) slot to each frame.
package demux4_pkg;

   typedef enum logic {
      HUNT,
      LOCKED
   } rx_state_t;

   localparam int SLOT_W = 3;
   localparam int MISS_W = 4;

`ifdef DEMUX4_PARITY_EN
   localparam int FRAME_LEN = 5;
`else
   localparam int FRAME_LEN = 4;
`endif

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_LEN - 1);

endpackage

// File: rtl/demux4_slot_ctr.sv
// Modulo-FRAME_LEN slot counter with advance, load-to-1 and clear.
// Priority: clear, then load-to-1, then advance.
module demux4_slot_ctr
   import demux4_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              load1,
   input  logic              clr,
   output logic [SLOT_W-1:0] slot
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot <= '0;
      end else if (clr) begin
         slot <= '0;
      end else if (load1) begin
         slot <= SLOT_W'(1);
      end else if (en) begin
         slot <= (slot == LAST_SLOT) ? '0 : slot + SLOT_W'(1);
      end
   end

endmodule

// File: rtl/demux4_tdm_rx.sv
// Serial TDM receiver: frames on sync and demultiplexes slots onto a..d.
// Define DEMUX4_PARITY_EN for a trailing even-parity slot and par_err.
module demux4_tdm_rx
   import demux4_pkg::*;
#(
   parameter int MISS_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              din,
   input  logic              sync,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              d,
   output logic              valid,
   output logic              locked,
   output logic [SLOT_W-1:0] slot,
   output logic              err,
   output logic              par_err
);

   rx_state_t          state_q, state_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic [FRAME_LEN-1:0] shadow;
   logic               ctr_adv, ctr_load1, ctr_clr;
   logic               wr;
   logic [SLOT_W-1:0]  wr_idx;
   logic               done;
   logic               err_d;

   demux4_slot_ctr u_slot_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (ctr_adv),
      .load1 (ctr_load1),
      .clr   (ctr_clr),
      .slot  (slot)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= HUNT;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         miss_q  <= miss_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      miss_d    = miss_q;
      ctr_adv   = 1'b0;
      ctr_load1 = 1'b0;
      ctr_clr   = 1'b0;
      wr        = 1'b0;
      wr_idx    = slot;
      done      = 1'b0;
      err_d     = 1'b0;
      if (en) begin
         unique case (state_q)
            HUNT: begin
               if (sync) begin
                  state_d   = LOCKED;
                  wr        = 1'b1;
                  wr_idx    = '0;
                  ctr_load1 = 1'b1;
                  miss_d    = '0;
               end
            end
            LOCKED: begin
               if (sync) begin
                  // Early sync restarts the frame at slot 0
                  err_d     = (slot != '0);
                  wr        = 1'b1;
                  wr_idx    = '0;
                  ctr_load1 = 1'b1;
                  miss_d    = '0;
               end else if (slot == '0 &&
                            miss_q == MISS_W'(MISS_MAX - 1)) begin
                  state_d = HUNT;
                  ctr_clr = 1'b1;
                  miss_d  = '0;
               end else begin
                  wr      = 1'b1;
                  ctr_adv = 1'b1;
                  done    = (slot == LAST_SLOT);
                  if (slot == '0) begin
                     miss_d = miss_q + MISS_W'(1);
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
      end else begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            if (wr && wr_idx == SLOT_W'(i)) begin
               shadow[i] <= din;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a       <= 1'b0;
         b       <= 1'b0;
         c       <= 1'b0;
         d       <= 1'b0;
         valid   <= 1'b0;
         err     <= 1'b0;
         par_err <= 1'b0;
      end else begin
         valid <= done;
         err   <= err_d;
`ifdef DEMUX4_PARITY_EN
         par_err <= done & (^{shadow[3:0], din});
`else
         par_err <= 1'b0;
`endif
         if (done) begin
            a <= shadow[0];
            b <= shadow[1];
            c <= shadow[2];
`ifdef DEMUX4_PARITY_EN
            d <= shadow[3];
`else
            d <= din;
`endif
         end
      end
   end

   assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_demux4_tdm_rx.sv
// Randomized bench for demux4_tdm_rx against a frame-level queue model.
// Build with DEMUX4_PARITY_EN to exercise the parity slot.
module tb_demux4_tdm_rx;

   localparam int MISS = 3;
`ifdef DEMUX4_PARITY_EN
   localparam int FL = 5;
`else
   localparam int FL = 4;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       din = 1'b0;
   logic       sync = 1'b0;
   logic       a, b, c, d;
   logic       valid, locked, err, par_err;
   logic [2:0] slot;

   int n_vec = 0;
   int n_bad = 0;

   bit       m_locked;
   bit       m_bits[$];
   int       m_miss;
   bit [3:0] m_abcd;
   bit       m_valid, m_err, m_par;

   demux4_tdm_rx #(.MISS_MAX(MISS)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .din     (din),
      .sync    (sync),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .valid   (valid),
      .locked  (locked),
      .slot    (slot),
      .err     (err),
      .par_err (par_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [15:0] got,
                      input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] dut_outs();
      return {a, b, c, d, valid, err, par_err, locked, 5'b0, slot};
   endfunction

   function automatic logic [15:0] exp_outs();
      logic [2:0] s;
      s = m_locked ? 3'(m_bits.size()) : 3'd0;
      return {m_abcd, m_valid, m_err, m_par, m_locked, 5'b0, s};
   endfunction

   task automatic model_reset();
      m_locked = 0;
      m_bits.delete();
      m_miss = 0;
      m_abcd = '0;
      m_valid = 0;
      m_err = 0;
      m_par = 0;
   endtask

   // Frame-level view: a frame is the list of bits since the last slot 0
   task automatic model_step(input bit e, input bit s, input bit x);
      bit p;
      m_valid = 0;
      m_err = 0;
      m_par = 0;
      if (!e) return;
      if (!m_locked) begin
         if (s) begin
            m_bits = '{x};
            m_locked = 1;
            m_miss = 0;
         end
      end else if (s) begin
         m_err = (m_bits.size() != 0);
         m_bits = '{x};
         m_miss = 0;
      end else if (m_bits.size() == 0) begin
         m_miss++;
         if (m_miss == MISS) begin
            m_locked = 0;
            m_miss = 0;
         end else begin
            m_bits.push_back(x);
         end
      end else begin
         m_bits.push_back(x);
         if (m_bits.size() == FL) begin
            p = 0;
            foreach (m_bits[i]) p ^= m_bits[i];
            m_abcd = {m_bits[0], m_bits[1], m_bits[2], m_bits[3]};
            m_valid = 1;
            m_par = (FL == 5) ? p : 1'b0;
            m_bits.delete();
         end
      end
   endtask

   task automatic cycle(input bit e, input bit s, input bit x,
                        input string tag);
      en = e;
      sync = s;
      din = x;
      @(posedge clk);
      model_step(e, s, x);
      #1;
      chk(tag, dut_outs(), exp_outs());
   endtask

   task automatic async_rst(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk(tag, dut_outs(), exp_outs());
      chk({tag, "_zero"}, dut_outs(), 16'h0000);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic frame(input bit s0, input bit [4:0] bits,
                        input string tag);
      cycle(1, s0, bits[4], tag);
      for (int i = 1; i < FL; i++) cycle(1, 0, bits[4-i], tag);
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1;
      chk("reset", dut_outs(), exp_outs());
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // 1,0,1,1 (+ even parity 1) with sync on the first bit
      frame(1, 5'b10111, "basic");
      chk("basic_abcd", {12'b0, a, b, c, d}, 16'h000B);
      chk("basic_vl", {14'b0, valid, locked}, 16'h0003);
      cycle(0, 0, 0, "basic_idle");
      chk("basic_vdrop", {15'b0, valid}, 16'h0000);

      // 1,1,0,0 with en every other cycle
      cycle(1, 1, 1, "gap");
      for (int i = 1; i < FL; i++) begin
         cycle(0, 0, 1, "gap_off");
         cycle(1, 0, (i == 1), "gap_on");
      end
      chk("gap_abcd", {12'b0, a, b, c, d}, 16'h000C);

      // withhold sync: lock drops at the third slot-0 bit
      frame(0, 5'b01100, "miss1");
      frame(0, 5'b11000, "miss2");
      cycle(1, 0, 1, "miss3");
      chk("miss_unlock", {15'b0, locked}, 16'h0000);
      for (int i = 0; i < 6; i++) cycle(1, 0, i[0], "hunt");
      chk("hunt_slot", {13'b0, slot}, 16'h0000);

      // sync at slot 2: err, slot restarts at 1
      cycle(1, 1, 0, "early");
      cycle(1, 0, 1, "early");
      cycle(1, 1, 1, "early_sync");
      chk("early_err", {13'b0, err, valid, 1'b0}, 16'h0004);
      chk("early_slot", {13'b0, slot}, 16'h0001);
      for (int i = 1; i < FL; i++) cycle(1, 0, 0, "early_tail");
      chk("early_valid", {15'b0, valid}, 16'h0001);

      // reset mid-frame, then first bit after release processed
      cycle(1, 1, 1, "mid");
      cycle(1, 0, 1, "mid");
      async_rst("mid_rst");
      frame(1, 5'b01011, "post_rst");

`ifdef DEMUX4_PARITY_EN
      frame(1, 5'b10110, "par_bad");
      chk("par_bad_pe", {14'b0, valid, par_err}, 16'h0003);
      frame(1, 5'b10111, "par_ok");
      chk("par_ok_pe", {14'b0, valid, par_err}, 16'h0002);
`endif

      for (int n = 0; n < 3000; n++) begin
         bit e, s, x;
         e = ($urandom_range(0, 9) < 7);
         x = 1'($urandom);
         if (!m_locked || m_bits.size() == 0)
            s = ($urandom_range(0, 9) < 6);
         else
            s = ($urandom_range(0, 24) == 0);
         cycle(e, s, x, "rand");
         if ($urandom_range(0, 499) == 0) async_rst("rand_rst");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/demux4_tdm_rx.md
DEMUX4_TDM_RX -- requirements
Module: demux4_tdm_rx

Interface
- REQ-001 SHALL have parameter MISS_MAX, default 3: consecutive frames whose slot 0 arrives without sync before lock is dropped; legal range 1..15.
- REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
- REQ-004 SHALL have port en, input, 1: bit strobe; one serial bit consumed per clk cycle with en=1.
- REQ-005 SHALL have port din, input, 1: serial TDM data bit.
- REQ-006 SHALL have port sync, input, 1: frame marker; qualified only when en=1; marks din as slot 0.
- REQ-007 SHALL have ports a, b, c, d, output, 1 each: registered channel outputs for slots 0, 1, 2, 3.
- REQ-008 SHALL have port valid, output, 1: one-cycle pulse when a..d take a new frame.
- REQ-009 SHALL have port locked, output, 1: high in LOCKED state.
- REQ-010 SHALL have port slot, output, 3: index of the slot that the next en bit fills.
- REQ-011 SHALL have port err, output, 1: one-cycle pulse on sync at nonzero slot.
- REQ-012 SHALL have port par_err, output, 1: parity mismatch pulse (see Configuration).

Function
- REQ-013 SHALL implement FSM with states HUNT and LOCKED.
- REQ-014 In HUNT, SHALL ignore din unless en&&sync; on en&&sync SHALL store din as slot 0, set slot=1, and enter LOCKED.
- REQ-015 In LOCKED on en, SHALL store din into shadow[slot] and advance slot modulo FRAME_LEN.
- REQ-016 On en at the last slot, SHALL load a..d from shadow (last bit direct from din) on the same edge and SHALL assert valid for exactly the following cycle.
- REQ-017 Output latency SHALL be 1 clk from the last-slot en edge. a..d SHALL hold between frames.
- REQ-018 On en&&sync at slot 0 in LOCKED, SHALL clear the miss counter.
- REQ-019 On en&&!sync at slot 0 in LOCKED, SHALL increment the miss counter and store the bit normally. When the counter reaches MISS_MAX, SHALL enter HUNT, discard the bit, and clear the counter.
- REQ-020 On en&&sync at slot!=0 in LOCKED, SHALL pulse err, discard the partial frame without asserting valid, store din as slot 0, set slot=1, and clear the miss counter.
- REQ-021 With en=0, SHALL leave all state unchanged; valid/err/par_err SHALL deassert.
- REQ-022 In HUNT, slot SHALL read 0.

Reset
- REQ-023 rst SHALL immediately force HUNT, slot=0, miss counter=0, a=b=c=d=0, and valid=err=par_err=locked=0, including mid-frame; the partial frame SHALL be lost.
- REQ-024 The first en edge after rst deasserts SHALL be processed normally.

Configuration
- REQ-025 Macro DEMUX4_PARITY_EN defined: FRAME_LEN=5; slot 4 carries even parity over slots 0..3; a..d and valid SHALL update after slot 4; par_err SHALL pulse with valid when the XOR of slots 0..4 is 1.
- REQ-026 Macro DEMUX4_PARITY_EN undefined: FRAME_LEN=4; par_err SHALL be tied 0.

Structure
- REQ-027 Package demux4_pkg SHALL hold the state enum (HUNT, LOCKED), SLOT_W=3, and FRAME_LEN, with FRAME_LEN conditional on DEMUX4_PARITY_EN.
- REQ-028 SHALL instantiate one sub-module demux4_slot_ctr, a modulo-FRAME_LEN counter with en, load-to-1, and clear.

Verification
- REQ-029 Reset, then en every cycle; sync on the first bit; din=1,0,1,1 -> one cycle later a=1, b=0, c=1, d=1, valid=1 for 1 cycle, locked=1.
- REQ-030 Frame 1,1,0,0 with en toggling every other cycle -> a..d=1100 after the 4th en bit; slot does not change on en=0 cycles.
- REQ-031 Locked stream, MISS_MAX=3, sync withheld for 3 frames -> locked falls at the 3rd slot-0 bit; no valid until the next sync.
- REQ-032 Sync asserted at slot 2 -> err pulse, no valid for that frame, slot=1 next; the next 3 bits complete a frame with valid.
- REQ-033 rst asserted at slot 2 -> outputs=0 and locked=0 immediately, without a clock edge.
- REQ-034 DEMUX4_PARITY_EN defined, frame 1,0,1,1 with parity bit 0 -> valid=1, par_err=1; with parity bit 1 -> valid=1, par_err=0.
